// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_seq
// Description : Multi-cycle signed 32x32 radix-2 Booth multiplier sequencer.
//               Borrows a shared external 32-bit adder: drives its A/B/Cin
//               each RUN cycle and folds S/ovf back into the partial product.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_ovf,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             q_m1;
    logic [CNT_W-1:0] cnt;
    logic             sum_sign;

    // The adder's high word always sees the partial product; only B/Cin vary.
    assign add_a    = p_hi;
    // Sign of the true 33-bit sum, recovered when the 32-bit adder overflows.
    assign sum_sign = add_s[WIDTH-1] ^ add_ovf;
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Booth select for the shared adder.
    always_comb begin
        next_state = state;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                case ({p_lo[0], q_m1})
                    2'b01: add_b = mcand;
                    2'b10: begin
                        add_b   = ~mcand;
                        add_cin = 1'b1;
                    end
                    default: add_b = '0;
                endcase
                if (cnt == LAST_STEP) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one Booth step plus arithmetic shift per RUN cycle, result latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand          <= '0;
            p_hi           <= '0;
            p_lo           <= '0;
            q_m1           <= 1'b0;
            cnt            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        mcand <= data_operandA;
                        p_lo  <= data_operandB;
                        p_hi  <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    p_hi <= {sum_sign, add_s[WIDTH-1:1]};
                    p_lo <= {add_s[0], p_lo[WIDTH-1:1]};
                    q_m1 <= p_lo[0];
                    cnt  <= cnt + 1'b1;
                end
                DONE: begin
                    data_result    <= p_lo;
                    data_exception <= (p_hi != {WIDTH{p_lo[WIDTH-1]}});
                    data_resultRDY <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult_seq
// Description : Scoreboard bench for booth_mult_seq with a behavioural adder
//               and a plain-arithmetic signed multiply reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_start = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_s;
    logic        add_ovf;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_cnt = 0;
    exp_t sb[$];

    booth_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .add_a          (add_a),
        .add_b          (add_b),
        .add_cin        (add_cin),
        .add_s          (add_s),
        .add_ovf        (add_ovf),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Shared adder stand-in: wide sum, signed overflow when bits 32 and 31 disagree.
    logic [33:0] full_sum;
    assign full_sum = {{2{add_a[31]}}, add_a} + {{2{add_b[31]}}, add_b} + {33'd0, add_cin};
    assign add_s    = full_sum[31:0];
    assign add_ovf  = full_sum[32] ^ full_sum[31];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {32'd0, data_result}, {32'd0, e.res});
                chk("exception", {63'd0, data_exception}, {63'd0, e.exc});
                chk("rdy_latency", 64'(cyc), 64'(e.due));
                chk("busy_at_rdy", {63'd0, busy}, 64'd0);
            end
            rdy_cnt++;
        end
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        int     ia;
        int     ib;
        longint p;
        ia    = a;
        ib    = b;
        p     = longint'(ia) * longint'(ib);
        e.res = p[31:0];
        e.exc = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        e.due = 0;
        return e;
    endfunction

    // Drive start during the low phase; the accepting edge is the next posedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e             = model(a, b);
        ctrl_start    = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        e.due = cyc + 33;
        sb.push_back(e);
        ctrl_start    = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy();
        int  n;
        bit  seen;
        n    = rdy_cnt;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (rdy_cnt > n) seen = 1'b1;
        end
        if (!seen) chk("rdy_timeout", 64'd0, 64'd1);
    endtask

    logic [31:0] dir_a [6];
    logic [31:0] dir_b [6];

    initial begin
        dir_a = '{32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000};
        dir_b = '{32'd5, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000, 32'd1};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
        chk("reset_result", {32'd0, data_result}, 64'd0);
        chk("reset_exc", {63'd0, data_exception}, 64'd0);
        chk("reset_add_a", {32'd0, add_a}, 64'd0);
        chk("reset_add_b", {31'd0, add_b, add_cin}, 64'd0);

        // Directed cases, issued back-to-back.
        for (int i = 0; i < 6; i++) begin
            issue(dir_a[i], dir_b[i]);
            wait_rdy();
        end

        // Randomized operands with a mix of small and full-range values.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) a = 32'($signed(16'($urandom)));
            if (i % 4 == 1) b = 32'($signed(12'($urandom)));
            if (i == 7) a = 32'h8000_0000;
            if (i == 9) b = 32'h8000_0000;
            issue(a, b);
            wait_rdy();
            if (i % 5 == 2) repeat ($urandom_range(1, 4)) @(negedge clock);
        end

        // Start pulses during a run are ignored; busy holds across RUN and DONE.
        @(negedge clock);
        #1;
        issue(32'd1234, 32'hFFFF_FFB3);
        for (int i = 1; i <= 33; i++) begin
            @(negedge clock);
            chk("busy_during_run", {63'd0, busy}, 64'd1);
            #1;
            ctrl_start = (i == 5 || i == 20);
            data_operandA = 32'd77;
            data_operandB = 32'd88;
        end
        ctrl_start = 1'b0;
        wait_rdy();
        repeat (3) @(negedge clock);
        chk("no_requeue", 64'(sb.size()), 64'd0);

        // Mid-run reset aborts silently and clears the result registers.
        issue(32'd1000, 32'd1000);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_result", {32'd0, data_result}, 64'd0);
        chk("abort_exc", {63'd0, data_exception}, 64'd0);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (data_resultRDY) pulses++;
            end
            chk("abort_no_rdy", 64'(pulses), 64'd0);
        end
        #1;
        issue(32'd2, 32'd9);
        wait_rdy();
        chk("post_abort_result", {32'd0, data_result}, 64'd18);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
